// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the audio-codec configuration sequencer:
// FSM states, WM8978 register map and the word-length encoding.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        StPwrup,
        StIssue,
        StWait,
        StGap,
        StDone,
        StErr,
        StUIssue,
        StUWait
    } cfg_state_e;

    // WM8978 register addresses used by the default init table
    localparam logic [6:0] RegSoftReset = 7'd0;
    localparam logic [6:0] RegPwrMgmt1  = 7'd1;
    localparam logic [6:0] RegPwrMgmt2  = 7'd2;
    localparam logic [6:0] RegPwrMgmt3  = 7'd3;
    localparam logic [6:0] RegAudioIf   = 7'd4;
    localparam logic [6:0] RegClkGen    = 7'd6;
    localparam logic [6:0] RegDacCtrl   = 7'd10;
    localparam logic [6:0] RegAdcCtrl   = 7'd14;
    localparam logic [6:0] RegBeepCtrl  = 7'd43;
    localparam logic [6:0] RegInputCtrl = 7'd44;
    localparam logic [6:0] RegLinpVol   = 7'd45;
    localparam logic [6:0] RegRinpVol   = 7'd46;
    localparam logic [6:0] RegLadcBoost = 7'd47;
    localparam logic [6:0] RegRadcBoost = 7'd48;
    localparam logic [6:0] RegOutCtrl   = 7'd49;
    localparam logic [6:0] RegLmixCtrl  = 7'd50;
    localparam logic [6:0] RegRmixCtrl  = 7'd51;
    localparam logic [6:0] RegLout1Vol  = 7'd52;
    localparam logic [6:0] RegRout1Vol  = 7'd53;

    function automatic logic wl_supported(input int unsigned wl);
        return (wl == 16) || (wl == 20) || (wl == 24) || (wl == 32);
    endfunction

    // R4 WL field encoding
    function automatic logic [1:0] wl_code(input int unsigned wl);
        logic [1:0] code;
        case (wl)
            16:      code = 2'b00;
            20:      code = 2'b01;
            24:      code = 2'b10;
            default: code = 2'b11;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational WM8978 init table: entry index -> {register address, data}.
// Indices at or beyond REG_NUM read as zero.
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int unsigned WL      = 32,
    parameter int unsigned AW      = 7,
    parameter int unsigned DW      = 9,
    parameter int unsigned REG_NUM = 19
) (
    input  logic [7:0]       idx_i,
    output logic [AW+DW-1:0] word_o
);

    localparam logic [1:0] WlCode = wl_code(WL);

    if (!wl_supported(WL)) begin : g_bad_wl
        $error("codec_cfg_rom: unsupported word length WL=%0d", WL);
    end

    logic [6:0] addr;
    logic [8:0] data;

    always_comb begin
        addr = '0;
        data = '0;
        if (32'(idx_i) < REG_NUM) begin
            case (idx_i)
                8'd0:  begin addr = RegSoftReset; data = 9'h000; end
                8'd1:  begin addr = RegPwrMgmt1;  data = 9'h01B; end
                8'd2:  begin addr = RegPwrMgmt2;  data = 9'h1B0; end
                8'd3:  begin addr = RegPwrMgmt3;  data = 9'h06C; end
                // I2S format, WL field in bits [6:5]
                8'd4:  begin addr = RegAudioIf;   data = {2'b00, WlCode, 5'b10000}; end
                8'd5:  begin addr = RegClkGen;    data = 9'h000; end
                8'd6:  begin addr = RegDacCtrl;   data = 9'h008; end
                8'd7:  begin addr = RegAdcCtrl;   data = 9'h108; end
                8'd8:  begin addr = RegBeepCtrl;  data = 9'h010; end
                8'd9:  begin addr = RegInputCtrl; data = 9'h000; end
                8'd10: begin addr = RegLinpVol;   data = 9'h13F; end
                8'd11: begin addr = RegRinpVol;   data = 9'h13F; end
                8'd12: begin addr = RegLadcBoost; data = 9'h100; end
                8'd13: begin addr = RegRadcBoost; data = 9'h100; end
                8'd14: begin addr = RegOutCtrl;   data = 9'h006; end
                8'd15: begin addr = RegLmixCtrl;  data = 9'h001; end
                8'd16: begin addr = RegRmixCtrl;  data = 9'h001; end
                8'd17: begin addr = RegLout1Vol;  data = 9'h13F; end
                8'd18: begin addr = RegRout1Vol;  data = 9'h13F; end
                default: begin addr = '0; data = '0; end
            endcase
        end
    end

    assign word_o = {AW'(addr), DW'(data)};

endmodule

// File: rtl/codec_cfg_seq.sv
// Codec register configuration sequencer: power-up delay, init-table walk with
// NACK retry, then single runtime user writes through the I2C driver handshake.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter int unsigned REG_NUM   = 19,
    parameter int unsigned AW        = 7,
    parameter int unsigned DW        = 9,
    parameter int unsigned WL        = 32,
    parameter int unsigned PWR_DLY   = 1023,
    parameter int unsigned GAP_DLY   = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             usr_req,
    input  logic [AW-1:0]    usr_addr,
    input  logic [DW-1:0]    usr_data,
    output logic             usr_busy,
    output logic             i2c_exec,
    output logic [AW+DW-1:0] i2c_word,
    input  logic             i2c_done,
    input  logic             i2c_nack,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [7:0]       cfg_idx
);

    localparam int unsigned WW     = AW + DW;
    localparam int unsigned MaxDly = (PWR_DLY > GAP_DLY) ? PWR_DLY : GAP_DLY;
    localparam int unsigned CntW   = (MaxDly < 2) ? 1 : $clog2(MaxDly);
    localparam int unsigned RtyW   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CntW-1:0] PwrLast = CntW'((PWR_DLY == 0) ? 0 : PWR_DLY - 1);
    localparam logic [CntW-1:0] GapLast = CntW'((GAP_DLY == 0) ? 0 : GAP_DLY - 1);
    localparam logic [RtyW-1:0] MaxRty  = RtyW'(MAX_RETRY);
    localparam logic [7:0]      LastIdx = 8'(REG_NUM - 1);

    if ((WW % 8) != 0) begin : g_bad_width
        $error("codec_cfg_seq: AW+DW=%0d is not a multiple of 8", WW);
    end
    if ((REG_NUM < 1) || (REG_NUM > 256)) begin : g_bad_reg_num
        $error("codec_cfg_seq: REG_NUM=%0d outside 1..256", REG_NUM);
    end

    cfg_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RtyW-1:0] rty_q, rty_d;
    logic [7:0]    idx_q, idx_d;
    logic          exec_q, exec_d;
    logic [WW-1:0] word_q, word_d;
    logic [WW-1:0] uword_q, uword_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [WW-1:0] rom_word;

    codec_cfg_rom #(
        .WL      (WL),
        .AW      (AW),
        .DW      (DW),
        .REG_NUM (REG_NUM)
    ) u_rom (
        .idx_i  (idx_q),
        .word_o (rom_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rty_d   = rty_q;
        idx_d   = idx_q;
        exec_d  = 1'b0;
        word_d  = word_q;
        uword_d = uword_q;
        done_d  = done_q;
        err_d   = err_q;
        busy_d  = busy_q;

        unique case (state_q)
            StPwrup: begin
                if (cnt_q == PwrLast) begin
                    cnt_d   = '0;
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StIssue: begin
                word_d  = rom_word;
                exec_d  = 1'b1;
                state_d = StWait;
            end

            StUIssue: begin
                word_d  = uword_q;
                exec_d  = 1'b1;
                state_d = StUWait;
            end

            StWait, StUWait: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        rty_d = '0;
                        if (state_q == StUWait) begin
                            busy_d  = 1'b0;
                            state_d = StGap;
                        end else if (idx_q == LastIdx) begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 8'd1;
                            state_d = StGap;
                        end
                    end else if (rty_q < MaxRty) begin
                        rty_d   = rty_q + 1'b1;
                        state_d = StGap;
                    end else begin
                        rty_d   = '0;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = StErr;
                    end
                end
            end

            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    // busy marks a user write being retried; done marks a finished user write
                    if (busy_q) begin
                        state_d = StUIssue;
                    end else if (done_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                if (start) begin
                    done_d  = 1'b0;
                    idx_d   = '0;
                    rty_d   = '0;
                    cnt_d   = '0;
                    state_d = StIssue;
                end else if (usr_req) begin
                    uword_d = {usr_addr, usr_data};
                    busy_d  = 1'b1;
                    state_d = StUIssue;
                end
            end

            StErr: begin
                if (start) begin
                    err_d   = 1'b0;
                    idx_d   = '0;
                    rty_d   = '0;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end

            default: state_d = StPwrup;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPwrup;
            cnt_q   <= '0;
            rty_q   <= '0;
            idx_q   <= '0;
            exec_q  <= 1'b0;
            word_q  <= '0;
            uword_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rty_q   <= rty_d;
            idx_q   <= idx_d;
            exec_q  <= exec_d;
            word_q  <= word_d;
            uword_q <= uword_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign i2c_exec = exec_q;
    assign i2c_word = word_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign usr_busy = busy_q;
    assign cfg_idx  = idx_q;

endmodule

// File: doc/codec_cfg_seq.md
Name: codec_cfg_seq

Overview:
Parametrised audio-codec register configuration sequencer: the next generation of the fixed WM8978 init-table walker.
- Waits a power-up delay after reset, then writes a REG_NUM-entry table through the existing I2C driver (exec/done handshake).
- Retries NACKed writes and flags failure.
- Accepts runtime single-register user writes (volume, mute, routing) once initialised.
- Sits between i2c_dri and the audio top; runs on the I2C driver's dri_clk.

Parameters:
REG_NUM, 19, number of init-table entries (1..256)
AW, 7, codec register address width
DW, 9, codec register data width; AW+DW is a multiple of 8
WL, 32, audio word length forwarded to the table ROM (16/20/24/32)
PWR_DLY, 1023, clk cycles from reset release to first write
GAP_DLY, 16, idle clk cycles between consecutive writes
MAX_RETRY, 3, re-attempts per entry after a NACK (0 = no retry)

Ports:
clk  in  1  sequencer clock (I2C driver operating clock)
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse: rerun full table from entry 0
usr_req  in  1  one-cycle pulse: request runtime write
usr_addr  in  AW  runtime write register address
usr_data  in  DW  runtime write data
usr_busy  out  1  runtime write accepted and in progress
i2c_exec  out  1  one-cycle pulse: start I2C write
i2c_word  out  AW+DW  {addr,data}; driver splits it into word-address/data bytes
i2c_done  in  1  one-cycle pulse: I2C operation finished
i2c_nack  in  1  valid with i2c_done: 1 = slave did not acknowledge
cfg_done  out  1  table written successfully; level
cfg_err  out  1  retries exhausted; sticky until start or reset
cfg_idx  out  8  current table index (debug/status)

Behaviour:
- Reset values: i2c_exec=0, i2c_word=0, cfg_done=0, cfg_err=0, usr_busy=0, cfg_idx=0, retry count=0, delay counter=0, state=PWRUP.
- Reset mid-transfer aborts immediately; the driver is reset by the same rst_n.
- States: PWRUP, ISSUE, WAIT, GAP, DONE, ERR, U_ISSUE, U_WAIT.
- PWRUP: count PWR_DLY cycles, then go to ISSUE.
- ISSUE:
  - i2c_word <= ROM word for cfg_idx.
  - i2c_exec=1 for exactly one cycle.
  - Go to WAIT.
- WAIT: hold i2c_word stable; wait for i2c_done.
  - i2c_done & !i2c_nack: clear retry count.
    - cfg_idx==REG_NUM-1: go to DONE, cfg_done=1 on the next cycle.
    - Otherwise: cfg_idx+1, go to GAP.
  - i2c_done & i2c_nack & retries<MAX_RETRY: retries+1, go to GAP, same index.
  - i2c_done & i2c_nack & retries==MAX_RETRY: cfg_err=1, go to ERR.
- GAP: count GAP_DLY cycles, then go to ISSUE.
- Latency: first i2c_exec occurs PWR_DLY+1 cycles after rst_n deasserts. Between an i2c_done and the next i2c_exec is GAP_DLY+1 cycles.
- DONE:
  - start: clear cfg_done, cfg_idx=0, go to ISSUE. No power-up delay.
  - usr_req (no start): latch usr_addr/usr_data, usr_busy=1 next cycle, go to U_ISSUE.
  - start and usr_req in the same cycle: start wins; the request is dropped and usr_busy stays 0.
- U_ISSUE/U_WAIT: same handshake and retry rules as ISSUE/WAIT, using the latched word.
  - Success: usr_busy=0, return to DONE after GAP_DLY cycles. cfg_done stays 1 throughout.
  - Exhausted retries: usr_busy=0, cfg_err=1, cfg_done=0, go to ERR.
- ERR: i2c_exec held 0; only start (restart from entry 0, clear cfg_err) or reset exits.
- Ignored inputs:
  - start and usr_req are ignored outside DONE/ERR.
  - usr_req is ignored in ERR.
  - i2c_done outside WAIT/U_WAIT is ignored.
- ROM word: {7'hxx reg addr, 9'hxxx data}. The entry that sets audio-interface word length encodes WL: 16→2'b00, 20→2'b01, 24→2'b10, 32→2'b11. Any other WL value is a generation-time error.

Decomposition:
- Package codec_cfg_pkg:
  - state enum.
  - WL-to-code function.
  - Default WM8978 register-address constants (R0 reset, R1/R2/R3 power, R4 interface, R6 clock, R52/R53 headphone volume, etc.).
- Sub-module codec_cfg_rom: combinational index→{addr,data} table. Parameters WL, AW, DW, REG_NUM; out-of-range index returns 0.
- The sequencer FSM and counters stay in codec_cfg_seq.

Test Plan:
- Reset release, I2C model always ACK, REG_NUM=19, PWR_DLY=1023 -> first i2c_exec at cycle 1024; 19 exec pulses with the ROM words in index order; cfg_done=1 after the 19th i2c_done; cfg_err=0.
- Model NACKs entry 5 twice, MAX_RETRY=3 -> entry 5 word issued 3 times, then entries 6..18 written; cfg_done=1.
- Model NACKs entry 2 always -> 4 attempts of entry 2; cfg_err=1; cfg_done=0; no further exec. Then start pulse -> cfg_err=0, restart at entry 0 with no power-up delay.
- In DONE: usr_req with usr_addr=7'h34, usr_data=9'h13F -> usr_busy=1 next cycle; one exec with i2c_word=16'h693F; usr_busy=0 after done; cfg_done stays 1.
- start and usr_req in the same cycle in DONE -> full table rerun from 0; no user write issued; usr_busy never asserts.
- rst_n asserted while in WAIT on entry 10 -> all outputs at reset values asynchronously; after release, the sequence restarts from PWRUP and entry 0.
